// File: rtl/hs_bus_axis_downsizer.sv
// AXI4-Stream width downsizer: one wide input beat leaves as up to RATIO narrow beats,
// LSB slice first, with null (all-zero keep) slices skipped.
module hs_bus_axis_downsizer #(
    parameter int M_DATA_WIDTH  = 8,
    parameter int RATIO         = 4,
    parameter int TID_WIDTH     = 1,
    parameter int TDEST_WIDTH   = 1,
    parameter int TUSER_WIDTH   = 1,
    localparam int S_DATA_WIDTH = M_DATA_WIDTH * RATIO,
    localparam int M_KEEP_WIDTH = M_DATA_WIDTH / 8,
    localparam int S_KEEP_WIDTH = S_DATA_WIDTH / 8
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic [S_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [S_KEEP_WIDTH-1:0] s_axis_tstrb,
    input  logic [S_KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                    s_axis_tlast,
    input  logic [TID_WIDTH-1:0]    s_axis_tid,
    input  logic [TDEST_WIDTH-1:0]  s_axis_tdest,
    input  logic [TUSER_WIDTH-1:0]  s_axis_tuser,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [M_DATA_WIDTH-1:0] m_axis_tdata,
    output logic [M_KEEP_WIDTH-1:0] m_axis_tstrb,
    output logic [M_KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                    m_axis_tlast,
    output logic [TID_WIDTH-1:0]    m_axis_tid,
    output logic [TDEST_WIDTH-1:0]  m_axis_tdest,
    output logic [TUSER_WIDTH-1:0]  m_axis_tuser
);

    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;

    typedef enum logic {EMPTY, BUSY} state_t;

    state_t                  state, state_next;
    logic                    run;
    logic [IDX_W-1:0]        idx, idx_next;
    logic [S_DATA_WIDTH-1:0] data_q;
    logic [S_KEEP_WIDTH-1:0] strb_q;
    logic [S_KEEP_WIDTH-1:0] keep_q;
    logic                    last_q;
    logic [TID_WIDTH-1:0]    id_q;
    logic [TDEST_WIDTH-1:0]  dest_q;
    logic [TUSER_WIDTH-1:0]  user_q;

    logic [RATIO-1:0]        nz_held, nz_in;
    logic                    has_next, any_in, finishing, load;
    logic [IDX_W-1:0]        next_idx, first_in;

    function automatic logic [RATIO-1:0] slice_nz(input logic [S_KEEP_WIDTH-1:0] keep);
        logic [RATIO-1:0] nz;
        for (int k = 0; k < RATIO; k++) begin
            nz[k] = |keep[k*M_KEEP_WIDTH +: M_KEEP_WIDTH];
        end
        return nz;
    endfunction

    // Descending scans leave the lowest qualifying slice in the result.
    always_comb begin
        nz_held  = slice_nz(keep_q);
        nz_in    = slice_nz(s_axis_tkeep);
        has_next = 1'b0;
        next_idx = '0;
        any_in   = 1'b0;
        first_in = '0;
        for (int k = RATIO - 1; k >= 0; k--) begin
            if (nz_held[k] && (k > int'(idx))) begin
                has_next = 1'b1;
                next_idx = IDX_W'(k);
            end
            if (nz_in[k]) begin
                any_in   = 1'b1;
                first_in = IDX_W'(k);
            end
        end
    end

    always_comb begin
        state_next    = state;
        idx_next      = idx;
        finishing     = (state == BUSY) && !has_next;
        m_axis_tvalid = (state == BUSY);
        m_axis_tlast  = last_q && !has_next;
        s_axis_tready = run && ((state == EMPTY) || (finishing && m_axis_tready));
        load          = s_axis_tvalid && s_axis_tready;
        case (state)
            EMPTY: ;
            BUSY: begin
                if (m_axis_tready) begin
                    if (has_next) idx_next = next_idx;
                    else          state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
        // A null beat without tlast carries nothing and never occupies the register.
        if (load) begin
            state_next = (any_in || s_axis_tlast) ? BUSY : EMPTY;
            idx_next   = any_in ? first_in : '0;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state <= EMPTY;
            idx   <= '0;
            run   <= 1'b0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            run   <= 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            data_q <= '0;
            strb_q <= '0;
            keep_q <= '0;
            last_q <= 1'b0;
            id_q   <= '0;
            dest_q <= '0;
            user_q <= '0;
        end else if (load) begin
            data_q <= s_axis_tdata;
            strb_q <= any_in ? s_axis_tstrb : '0;
            keep_q <= s_axis_tkeep;
            last_q <= s_axis_tlast;
            id_q   <= s_axis_tid;
            dest_q <= s_axis_tdest;
            user_q <= s_axis_tuser;
        end
    end

    always_comb begin
        m_axis_tdata = '0;
        m_axis_tkeep = '0;
        m_axis_tstrb = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (idx == IDX_W'(k)) begin
                m_axis_tdata = data_q[k*M_DATA_WIDTH +: M_DATA_WIDTH];
                m_axis_tkeep = keep_q[k*M_KEEP_WIDTH +: M_KEEP_WIDTH];
                m_axis_tstrb = strb_q[k*M_KEEP_WIDTH +: M_KEEP_WIDTH];
            end
        end
    end

    assign m_axis_tid   = id_q;
    assign m_axis_tdest = dest_q;
    assign m_axis_tuser = user_q;

endmodule
